// File: rtl/dmem_port_arbiter_pkg.sv
// Shared FSM state and port-id encodings for the datamem port arbiter.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_port_arbiter_pick.sv
// Combinational grant between core (C) and debug (D) requesters.
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin on contention; default is C-priority.
module dmem_port_arbiter_pick
  import dmem_port_arbiter_pkg::*;
(
  input  logic c_valid,
  input  logic d_valid,
  input  logic rr_last,
  output logic grant_c,
  output logic grant_d
);

  logic prefer_c;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // On contention, favour whichever port did not win the previous handshake.
  assign prefer_c = (rr_last == PORT_D);
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
  assign prefer_c       = 1'b1;
`endif

  always_comb begin
    grant_c = c_valid & (~d_valid | prefer_c);
    grant_d = d_valid & (~c_valid | ~prefer_c);
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares single-port datamem between the MEM stage (C) and a debug/loader port (D).
// One transaction in flight: IDLE (grant) -> ACCESS (mem strobe) -> RESP (response pulse).
// Build option: DMEM_ARB_ROUND_ROBIN_EN (see dmem_port_arbiter_pick).
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned MEM_DEPTH = 32,
  localparam int unsigned BE_W      = DATA_W / 8,
  localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  input  logic [BE_W-1:0]   c_req_be,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_rdata,
  output logic              c_rsp_err,
  output logic              core_stall,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [BE_W-1:0]   d_req_be,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              d_rsp_err,

  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q;
  port_e               owner_q;
  port_e               rr_last_q;
  logic                we_q;
  logic                err_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic                c_rsp_valid_q;
  logic                c_rsp_err_q;
  logic                d_rsp_valid_q;
  logic                d_rsp_err_q;

  logic                grant_c;
  logic                grant_d;
  logic                idle;
  logic                handshake;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;
  logic                sel_err;

  dmem_port_arbiter_pick u_pick (
    .c_valid (c_req_valid),
    .d_valid (d_req_valid),
    .rr_last (rr_last_q == PORT_D),
    .grant_c (grant_c),
    .grant_d (grant_d)
  );

  assign idle        = (state_q == ST_IDLE);
  assign c_req_ready = idle & grant_c;
  assign d_req_ready = idle & grant_d;
  assign handshake   = c_req_ready | d_req_ready;
  assign core_stall  = c_req_valid & ~c_req_ready;

  always_comb begin
    sel_we    = c_req_we;
    sel_addr  = c_req_addr;
    sel_wdata = c_req_wdata;
    sel_be    = c_req_be;
    if (grant_d) begin
      sel_we    = d_req_we;
      sel_addr  = d_req_addr;
      sel_wdata = d_req_wdata;
      sel_be    = d_req_be;
    end
    sel_err = (sel_addr[1:0] != 2'b00) | (sel_addr[ADDR_W-1:MEM_AW] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= PORT_C;
      rr_last_q     <= PORT_D;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      c_rsp_valid_q <= 1'b0;
      c_rsp_err_q   <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            owner_q     <= grant_d ? PORT_D : PORT_C;
            rr_last_q   <= grant_d ? PORT_D : PORT_C;
            we_q        <= sel_we;
            err_q       <= sel_err;
            // Memory strobe is launched at the grant edge so it is visible during ACCESS.
            mem_en_q    <= ~sel_err;
            mem_we_q    <= sel_we & ~sel_err;
            mem_addr_q  <= sel_addr[MEM_AW-1:0];
            mem_wdata_q <= sel_wdata;
            mem_be_q    <= sel_be;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_en_q      <= 1'b0;
          mem_we_q      <= 1'b0;
          c_rsp_valid_q <= (owner_q == PORT_C);
          c_rsp_err_q   <= (owner_q == PORT_C) & err_q;
          d_rsp_valid_q <= (owner_q == PORT_D);
          d_rsp_err_q   <= (owner_q == PORT_D) & err_q;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          c_rsp_valid_q <= 1'b0;
          c_rsp_err_q   <= 1'b0;
          d_rsp_valid_q <= 1'b0;
          d_rsp_err_q   <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  // Read data arrives from datamem during RESP, so it is gated rather than registered.
  assign c_rsp_valid = c_rsp_valid_q;
  assign c_rsp_err   = c_rsp_err_q;
  assign c_rsp_rdata = (c_rsp_valid_q & ~we_q & ~err_q) ? mem_rdata : '0;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign d_rsp_rdata = (d_rsp_valid_q & ~we_q & ~err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: transaction-level timing model plus directed tests.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req_valid, c_req_ready, c_req_we;
  logic [31:0] c_req_addr, c_req_wdata;
  logic [3:0]  c_req_be;
  logic        c_rsp_valid, c_rsp_err, core_stall;
  logic [31:0] c_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [3:0]  d_req_be;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_req_be(c_req_be),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
    .core_stall(core_stall),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  req_t c_q[$];
  req_t d_q[$];
  bit   gseq[$];          // DUT grant order, 0 = C, 1 = D

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Model state: cycle of the last handshake and the transaction it carried.
  int          last_hs   = -100;
  bit          last_win  = 1'b1;
  bit          cur_owner = 1'b0;
  bit          cur_we    = 1'b0;
  bit          cur_err   = 1'b0;
  logic [31:0] cur_addr  = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_be    = '0;
  logic [31:0] cur_rdata = '0;
  logic [7:0]  ref_mem [32];

  // DUT observation bookkeeping.
  bit          c_hs = 1'b0;
  bit          d_hs = 1'b0;
  int          c_hs_cyc = -100;
  int          men_cnt = 0, c_rsp_cnt = 0, d_rsp_cnt = 0, c_err_cnt = 0;
  logic [31:0] waddr_last = '0, c_rd_last = '0, d_rd_last = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Environment datamem: synchronous read, byte-enabled write.
  initial begin
    logic [7:0] env_mem [32];
    for (int i = 0; i < 32; i++) env_mem[i] = 8'h10 + 8'(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) begin
          for (int k = 0; k < 4; k++)
            if (mem_be[k]) env_mem[(int'(mem_addr) + k) % 32] = mem_wdata[8*k +: 8];
        end else begin
          mem_rdata <= {env_mem[(int'(mem_addr) + 3) % 32], env_mem[(int'(mem_addr) + 2) % 32],
                        env_mem[(int'(mem_addr) + 1) % 32], env_mem[int'(mem_addr)]};
        end
      end
    end
  end

  // Request drivers: hold the queue head until it is accepted.
  initial begin
    c_req_valid = 0; c_req_we = 0; c_req_addr = '0; c_req_wdata = '0; c_req_be = '0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_be = '0;
    forever begin
      @(posedge clk); #1;
      if (c_hs) begin c_hs = 0; if (c_q.size() > 0) c_q.delete(0); end
      if (d_hs) begin d_hs = 0; if (d_q.size() > 0) d_q.delete(0); end
      if (c_q.size() > 0) begin
        c_req_valid = 1; c_req_we = c_q[0].we; c_req_addr = c_q[0].addr;
        c_req_wdata = c_q[0].wdata; c_req_be = c_q[0].be;
      end else begin
        c_req_valid = 0; c_req_we = 0; c_req_addr = '0; c_req_wdata = '0; c_req_be = '0;
      end
      if (d_q.size() > 0) begin
        d_req_valid = 1; d_req_we = d_q[0].we; d_req_addr = d_q[0].addr;
        d_req_wdata = d_q[0].wdata; d_req_be = d_q[0].be;
      end else begin
        d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_be = '0;
      end
    end
  end

  // Compare process: expected outputs from handshake timing and a byte-array memory.
  initial begin
    bit free, acc, rsp, pick_c, e_c_rdy, e_d_rdy, e_men, e_crv, e_drv;
    logic [31:0] e_rd, a;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h10 + 8'(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_hs  = -100;
        last_win = 1'b1;
        chk("rst_c_req_ready", 32'(c_req_ready), 0);
        chk("rst_d_req_ready", 32'(d_req_ready), 0);
        chk("rst_core_stall",  32'(core_stall),  0);
        chk("rst_mem_en",      32'(mem_en),      0);
        chk("rst_mem_we",      32'(mem_we),      0);
        chk("rst_mem_addr",    32'(mem_addr),    0);
        chk("rst_mem_wdata",   mem_wdata,        0);
        chk("rst_mem_be",      32'(mem_be),      0);
        chk("rst_c_rsp_valid", 32'(c_rsp_valid), 0);
        chk("rst_c_rsp_err",   32'(c_rsp_err),   0);
        chk("rst_c_rsp_rdata", c_rsp_rdata,      0);
        chk("rst_d_rsp_valid", 32'(d_rsp_valid), 0);
        chk("rst_d_rsp_err",   32'(d_rsp_err),   0);
        chk("rst_d_rsp_rdata", d_rsp_rdata,      0);
      end else begin
        free = (cyc >= last_hs + 3);
        acc  = (cyc == last_hs + 1);
        rsp  = (cyc == last_hs + 2);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        pick_c = last_win;
`else
        pick_c = 1'b1;
`endif
        e_c_rdy = free && c_req_valid && (!d_req_valid || pick_c);
        e_d_rdy = free && d_req_valid && (!c_req_valid || !pick_c);
        e_men   = acc && !cur_err;
        chk("c_req_ready", 32'(c_req_ready), 32'(e_c_rdy));
        chk("d_req_ready", 32'(d_req_ready), 32'(e_d_rdy));
        chk("core_stall",  32'(core_stall),  32'(c_req_valid && !e_c_rdy));
        chk("mem_en",      32'(mem_en),      32'(e_men));
        if (e_men) begin
          chk("mem_we",   32'(mem_we),   32'(cur_we));
          chk("mem_addr", 32'(mem_addr), 32'(cur_addr[4:0]));
          if (cur_we) begin
            chk("mem_wdata", mem_wdata,    cur_wdata);
            chk("mem_be",    32'(mem_be),  32'(cur_be));
          end
        end
        e_crv = rsp && !cur_owner;
        e_drv = rsp && cur_owner;
        e_rd  = (cur_we || cur_err) ? 32'h0 : cur_rdata;
        chk("c_rsp_valid", 32'(c_rsp_valid), 32'(e_crv));
        chk("c_rsp_err",   32'(c_rsp_err),   32'(e_crv && cur_err));
        chk("c_rsp_rdata", c_rsp_rdata,      e_crv ? e_rd : 32'h0);
        chk("d_rsp_valid", 32'(d_rsp_valid), 32'(e_drv));
        chk("d_rsp_err",   32'(d_rsp_err),   32'(e_drv && cur_err));
        chk("d_rsp_rdata", d_rsp_rdata,      e_drv ? e_rd : 32'h0);
        if (e_c_rdy || e_d_rdy) begin
          cur_owner = e_d_rdy;
          last_win  = e_d_rdy;
          last_hs   = cyc;
          cur_we    = e_d_rdy ? d_req_we    : c_req_we;
          a         = e_d_rdy ? d_req_addr  : c_req_addr;
          cur_wdata = e_d_rdy ? d_req_wdata : c_req_wdata;
          cur_be    = e_d_rdy ? d_req_be    : c_req_be;
          cur_addr  = a;
          cur_err   = (a[1:0] != 2'b00) || (a >= 32);
          cur_rdata = '0;
          if (!cur_err) begin
            for (int k = 0; k < 4; k++) cur_rdata[8*k +: 8] = ref_mem[a[4:0] + 5'(k)];
            if (cur_we)
              for (int k = 0; k < 4; k++)
                if (cur_be[k]) ref_mem[a[4:0] + 5'(k)] = cur_wdata[8*k +: 8];
          end
        end
      end
      if (c_req_valid && c_req_ready) begin c_hs = 1; c_hs_cyc = cyc; gseq.push_back(1'b0); end
      if (d_req_valid && d_req_ready) begin d_hs = 1; gseq.push_back(1'b1); end
      if (mem_en) begin men_cnt++; if (mem_we) waddr_last = 32'(mem_addr); end
      if (c_rsp_valid) begin
        c_rsp_cnt++;
        chk("c_latency", 32'(cyc - c_hs_cyc), 2);
        if (c_rsp_err) c_err_cnt++; else c_rd_last = c_rsp_rdata;
      end
      if (d_rsp_valid) begin
        d_rsp_cnt++;
        if (!d_rsp_err) d_rd_last = d_rsp_rdata;
      end
    end
  end

  function automatic req_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
    return r;
  endfunction

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(posedge clk); #3;
      ok = (c_q.size() == 0) && (d_q.size() == 0) && !c_req_valid && !d_req_valid &&
           (cyc >= last_hs + 3);
    end
    if (!ok) begin
      nchk++; nerr++;
      $display("FAIL %s_timeout: got busy, expected idle within 300 cycles", nm);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #2;
  endtask

  initial begin
    int c0, e0, m0, n;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_en", 32'(mem_en), 0);
    chk("reset_c_rsp_valid", 32'(c_rsp_valid), 0);
    @(posedge clk); #1 rst_n = 1;
    #2;

    // 1: core store then load at 0x08
    c_q.push_back(mk(1, 32'h08, 32'hDEADBEEF, 4'hF));
    c_q.push_back(mk(0, 32'h08, 32'h0, 4'h0));
    wait_idle("t1");
    chk("t1_waddr", waddr_last, 32'h8);
    chk("t1_load_rdata", c_rd_last, 32'hDEADBEEF);

    // 2: out-of-range and misaligned loads
    e0 = c_err_cnt; m0 = men_cnt;
    c_q.push_back(mk(0, 32'h22, 32'h0, 4'h0));
    c_q.push_back(mk(0, 32'h05, 32'h0, 4'h0));
    wait_idle("t2");
    chk("t2_err_count", 32'(c_err_cnt - e0), 2);
    chk("t2_mem_en_count", 32'(men_cnt - m0), 0);

    // 3: contention from a fresh reset, 4 rounds each
    pulse_reset();
    gseq.delete();
    for (int i = 0; i < 4; i++) begin
      c_q.push_back(mk(0, 32'(4 * i), 32'h0, 4'h0));
      d_q.push_back(mk(0, 32'(16 + 4 * i), 32'h0, 4'h0));
    end
    wait_idle("t3");
    chk("t3_grant_count", 32'(gseq.size()), 8);
    if (gseq.size() >= 4)
      for (int i = 0; i < 4; i++)
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        chk($sformatf("t3_grant%0d", i), 32'(gseq[i]), 32'(i % 2));
`else
        chk($sformatf("t3_grant%0d", i), 32'(gseq[i]), 0);
`endif

    // 4: debug byte store then load at 0x10
    d_q.push_back(mk(1, 32'h10, 32'h0000_00AA, 4'h1));
    d_q.push_back(mk(0, 32'h10, 32'h0, 4'h0));
    wait_idle("t4");
    chk("t4_load_rdata", d_rd_last, 32'h2322_21AA);

    // 5: reset during the ACCESS cycle of a load
    c_q.push_back(mk(0, 32'h0C, 32'h0, 4'h0));
    n = 0;
    do begin @(negedge clk); n++; end while (!(c_req_valid && c_req_ready) && n < 20);
    chk("t5_handshake_seen", 32'(c_req_valid && c_req_ready), 1);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("t5_mem_en", 32'(mem_en), 0);
    chk("t5_c_rsp_valid", 32'(c_rsp_valid), 0);
    c0 = c_rsp_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #2 c_q.push_back(mk(0, 32'h0C, 32'h0, 4'h0));
    @(posedge clk);
    @(negedge clk);
    chk("t5_regrant_ready", 32'(c_req_ready), 1);
    wait_idle("t5");
    chk("t5_rsp_count", 32'(c_rsp_cnt - c0), 1);
    chk("t5_load_rdata", c_rd_last, 32'h1F1E_1D1C);

    // 6: D held valid while C issues 10 loads
    gseq.delete();
    c0 = c_rsp_cnt;
    for (int i = 0; i < 10; i++) c_q.push_back(mk(0, 32'((4 * i) % 32), 32'h0, 4'h0));
    d_q.push_back(mk(0, 32'h14, 32'h0, 4'h0));
    wait_idle("t6");
    chk("t6_c_rsp_count", 32'(c_rsp_cnt - c0), 10);
    chk("t6_grant_count", 32'(gseq.size()), 11);
`ifndef DMEM_ARB_ROUND_ROBIN_EN
    if (gseq.size() >= 11) begin
      for (int i = 0; i < 10; i++) chk($sformatf("t6_grant%0d", i), 32'(gseq[i]), 0);
      chk("t6_d_last", 32'(gseq[10]), 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected summary before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
